// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID latch: owns the PC, reads the icache, and
// keeps a one-entry skid buffer so a word returned during a stall is not lost.
module fetch_stage #(
    parameter logic [31:0] PC_INIT  = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_plus4;
    logic [31:0] instr_p1, instr_n;
    logic [31:0] pc4_p1, pc4_n;
    logic        vld_p1, vld_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc4, skid_pc4_n;

    assign pc_plus4 = pc + 32'd4;
    assign iaddr    = pc;
    assign iREN     = (state == FETCH);
    assign halted   = (state == HALTED);
    assign instr    = instr_p1;
    assign pc4      = pc4_p1;
    assign valid    = vld_p1;

    // Fetch -> IF/ID boundary
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            instr_p1   <= NOP_WORD;
            pc4_p1     <= 32'd0;
            vld_p1     <= 1'b0;
            skid_instr <= 32'd0;
            skid_pc4   <= 32'd0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            instr_p1   <= instr_n;
            pc4_p1     <= pc4_n;
            vld_p1     <= vld_n;
            skid_instr <= skid_instr_n;
            skid_pc4   <= skid_pc4_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = instr_p1;
        pc4_n        = pc4_p1;
        vld_n        = vld_p1;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;

        if (halt) begin
            state_n      = HALTED;
            instr_n      = NOP_WORD;
            vld_n        = 1'b0;
            skid_instr_n = 32'd0;
            skid_pc4_n   = 32'd0;
        end else if (state == HALTED) begin
            state_n = HALTED;
        end else if (redirect) begin
            // Masking keeps pc word-aligned even for a misaligned target.
            pc_n         = redirect_pc & ~32'd3;
            state_n      = FETCH;
            instr_n      = NOP_WORD;
            vld_n        = 1'b0;
            skid_instr_n = 32'd0;
            skid_pc4_n   = 32'd0;
        end else if (state == HOLD) begin
            if (!stall) begin
                state_n      = FETCH;
                instr_n      = skid_instr;
                pc4_n        = skid_pc4;
                vld_n        = 1'b1;
                skid_instr_n = 32'd0;
                skid_pc4_n   = 32'd0;
            end
        end else if (stall) begin
            if (ihit) begin
                state_n      = HOLD;
                skid_instr_n = iload;
                skid_pc4_n   = pc_plus4;
                pc_n         = pc_plus4;
            end
        end else if (ihit) begin
            instr_n = iload;
            pc4_n   = pc_plus4;
            vld_n   = 1'b1;
            pc_n    = pc_plus4;
        end else begin
            instr_n = NOP_WORD;
            vld_n   = 1'b0;
        end
    end

endmodule
